// File: rtl/axis_instr_tx.sv
// axis_instr_tx: encodes host commands into AXIS instruction packets.
// Optional AXIS_TX_TLAST_EN adds m_axis_tlast on the final packet.
module axis_instr_tx #(
  parameter int INP_WIDTH = 8,
  parameter int OPC_W     = 3,
  parameter int IDX_W     = 1,
  parameter int VAL_W     = 2,
  parameter int DLY_W     = 2,
  parameter int RUN_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IDX_W-1:0]     cmd_idx,
  input  logic [VAL_W-1:0]     cmd_val,
  input  logic [DLY_W-1:0]     cmd_dly,
  input  logic [RUN_CNT_W-1:0] cmd_run,
  output logic [INP_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
`ifdef AXIS_TX_TLAST_EN
  output logic                 m_axis_tlast,
`endif
  output logic                 busy
);

  localparam int OPR_W = INP_WIDTH - OPC_W;
  localparam int unsigned RUN_MAX_I = (1 << OPR_W) - 1;
  localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(RUN_MAX_I);

  localparam logic [OPC_W-1:0] OPC_RUN = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_AS  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_CLR = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_DEC = OPC_W'(4);

  generate
    if (IDX_W + VAL_W + DLY_W != OPR_W) begin : g_bad_fields
      $error("AS fields must fill the operand");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q;
  logic [INP_WIDTH-1:0]   tdata_q;
  logic                   tvalid_q;
  logic [RUN_CNT_W-1:0]   rem_q;
  logic                   tlast_q;

  logic [OPR_W-1:0]       cmd_chunk;
  logic [OPR_W-1:0]       rem_chunk;
  logic                   cmd_hs;
  logic                   split_hs;
  logic                   fin_hs;

  // Largest RUN slice that fits the operand, for a new command and for rem.
  always_comb begin
    cmd_chunk = (cmd_run > RUN_MAX) ? OPR_W'(RUN_MAX_I)
                                    : cmd_run[OPR_W-1:0];
    rem_chunk = (rem_q > RUN_MAX) ? OPR_W'(RUN_MAX_I)
                                  : rem_q[OPR_W-1:0];
  end

  assign split_hs = (state_q == SEND) && m_axis_tready
                    && (rem_q != '0);
  assign fin_hs   = (state_q == SEND) && m_axis_tready
                    && (rem_q == '0);
  assign cmd_ready = !rst && ((state_q == IDLE) || fin_hs);
  assign cmd_hs    = cmd_valid && cmd_ready;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q == SEND);
`ifdef AXIS_TX_TLAST_EN
  assign m_axis_tlast  = tlast_q;
`else
  logic unused_tlast;
  assign unused_tlast = tlast_q;
`endif

  // Command/packet FSM; a final handshake may accept the next command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      rem_q    <= '0;
      tlast_q  <= 1'b0;
    end else if (split_hs) begin
      tdata_q <= {OPC_RUN, rem_chunk};
      rem_q   <= rem_q - RUN_CNT_W'(rem_chunk);
      tlast_q <= (rem_q <= RUN_MAX);
    end else if (cmd_hs) begin
      unique case (cmd_op)
        2'd0: begin
          tdata_q  <= {OPC_CLR, {OPR_W{1'b0}}};
          tlast_q  <= 1'b1;
          tvalid_q <= 1'b1;
          state_q  <= SEND;
        end
        2'd1: begin
          tdata_q  <= {OPC_AS, cmd_idx, cmd_val, cmd_dly};
          tlast_q  <= 1'b1;
          tvalid_q <= 1'b1;
          state_q  <= SEND;
        end
        2'd2: begin
          if (cmd_run == '0) begin
            tvalid_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            tdata_q  <= {OPC_RUN, cmd_chunk};
            rem_q    <= cmd_run - RUN_CNT_W'(cmd_chunk);
            tlast_q  <= (cmd_run <= RUN_MAX);
            tvalid_q <= 1'b1;
            state_q  <= SEND;
          end
        end
        default: begin
          tdata_q  <= {OPC_DEC, {OPR_W{1'b0}}};
          tlast_q  <= 1'b1;
          tvalid_q <= 1'b1;
          state_q  <= SEND;
        end
      endcase
    end else if (fin_hs) begin
      tvalid_q <= 1'b0;
      state_q  <= IDLE;
    end
  end

endmodule
